bcd_serial_sub: RTL and testbench

- Digit-serial multi-digit BCD subtractor: computes A − B, one BCD digit per clock, least-significant digit first.
- Subtraction counterpart of the team's combinational BCD adder. Serves decimal arithmetic paths that need a difference and a sign.
- Operands are captured on a start handshake. Result is reported with a one-cycle done pulse and held until the next operation.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_sub.sv | 24 ++
 rtl/bcd_serial_sub.sv | 142 ++++++++++++++
 tb/tb_bcd_serial_sub.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD subtractor.
// Included by bcd_digit_sub and bcd_serial_sub.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    CMP,
    DONE
  } state_t;

  localparam int BCD_RADIX = 10;
  localparam int BCD_MAX   = 9;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract-with-borrow: d = x - y - bin (mod 10).
// Purely combinational; shared by the subtract and complement passes.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout
);

  logic signed [4:0] t;
  logic signed [4:0] tw;

  // 5-bit signed difference; a negative result wraps by adding the radix
  always_comb begin
    t    = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0, bin});
    tw   = t + 5'(BCD_RADIX);
    bout = t[4];
    d    = bout ? tw[3:0] : t[3:0];
  end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor A - B, LSD first, one digit per clock.
// Define BCD_SIGN_MAG_EN for a sign-magnitude result (extra CMP pass).
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                borrow,
  output logic                neg
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t                  state_q;
  logic [IW-1:0]           idx_q;
  logic                    bin_q;
  bcd_digit_t [DIGITS-1:0] a_q;
  bcd_digit_t [DIGITS-1:0] b_q;
  bcd_digit_t [DIGITS-1:0] diff_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    borrow_q;
  logic                    neg_q;

  bcd_digit_t x_d;
  bcd_digit_t y_d;
  bcd_digit_t dig_d;
  logic       bout_d;

  // Operand select for the shared digit unit: A/B digits, or 0 - diff
  always_comb begin
    x_d = a_q[idx_q];
    y_d = b_q[idx_q];
`ifdef BCD_SIGN_MAG_EN
    if (state_q == CMP) begin
      x_d = '0;
      y_d = diff_q[idx_q];
    end
`endif
  end

  bcd_digit_sub u_dsub (
    .x    (x_d),
    .y    (y_d),
    .bin  (bin_q),
    .d    (dig_d),
    .bout (bout_d)
  );

  // Control FSM with registered status and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      bin_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            bin_q    <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= SUB;
          end
        end
        SUB: begin
          diff_q[idx_q] <= dig_d;
          bin_q         <= bout_d;
          idx_q         <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_q    <= '0;
            borrow_q <= bout_d;
`ifdef BCD_SIGN_MAG_EN
            if (bout_d) begin
              bin_q   <= 1'b0;
              state_q <= CMP;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
`else
            neg_q   <= bout_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`endif
          end
        end
`ifdef BCD_SIGN_MAG_EN
        CMP: begin
          diff_q[idx_q] <= dig_d;
          bin_q         <= bout_d;
          idx_q         <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_q   <= '0;
            neg_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign neg    = neg_q;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Self-checking bench for bcd_serial_sub (DIGITS=4).
// Checks against an integer-arithmetic model of A - B.
module tb_bcd_serial_sub;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [4*N-1:0] a = '0;
  logic [4*N-1:0] b = '0;
  logic           busy;
  logic           done;
  logic [4*N-1:0] diff;
  logic           borrow;
  logic           neg;

  bcd_serial_sub #(.DIGITS(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .neg    (neg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [4*N-1:0] diff;
    logic           borrow;
    logic           neg;
    int             dly;
  } res_t;

  function automatic int bcd2int(logic [4*N-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [4*N-1:0] int2bcd(int v);
    logic [4*N-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic res_t model(logic [4*N-1:0] ma, logic [4*N-1:0] mb);
    res_t m;
    int   pw = 1;
    int   dv;
    for (int i = 0; i < N; i++) pw = pw * 10;
    dv = bcd2int(ma) - bcd2int(mb);
    m.borrow = (dv < 0);
    m.dly = N;
`ifdef BCD_SIGN_MAG_EN
    if (dv < 0) begin
      m.diff = int2bcd(-dv);
      m.neg = 1'b1;
      m.dly = 2 * N;
    end else begin
      m.diff = int2bcd(dv);
      m.neg = 1'b0;
    end
`else
    m.diff = int2bcd(dv < 0 ? dv + pw : dv);
    m.neg = m.borrow;
`endif
    return m;
  endfunction

  logic ex_on = 1'b0;
  int   t_acc = 0;
  res_t ex;

  // Cycle-by-cycle compare against the model schedule of the current op
  always @(negedge clk) begin
    int n;
    if (ex_on && rst_n) begin
      n = cyc - t_acc;
      chk("busy", 32'(busy), 32'(n < ex.dly));
      chk("done", 32'(done), 32'(n == ex.dly));
      if (n == 0) begin
        chk("clr_diff", 32'(diff), 32'(0));
        chk("clr_borrow", 32'(borrow), 32'(0));
        chk("clr_neg", 32'(neg), 32'(0));
      end else if (n >= ex.dly) begin
        chk("diff", 32'(diff), 32'(ex.diff));
        chk("borrow", 32'(borrow), 32'(ex.borrow));
        chk("neg", 32'(neg), 32'(ex.neg));
      end
    end
  end

  task automatic launch(logic [4*N-1:0] va, logic [4*N-1:0] vb);
    res_t nx;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    nx = model(va, vb);
    @(posedge clk);
    #1;
    start = 1'b0;
    ex = nx;
    t_acc = cyc;
    ex_on = 1'b1;
  endtask

  task automatic wait_done();
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'(1));
    chk("latency", 32'(cyc - t_acc), 32'(ex.dly));
  endtask

  task automatic run(logic [4*N-1:0] va, logic [4*N-1:0] vb);
    launch(va, vb);
    wait_done();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    res_t r;

    #12;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_diff", 32'(diff), 32'(0));
    chk("rst_borrow", 32'(borrow), 32'(0));
    chk("rst_neg", 32'(neg), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    r = model(16'h5321, 16'h1234);
    chk("m_5321_1234", 32'({r.diff, r.borrow, r.neg}), 32'({16'h4087, 2'b00}));
    chk("m_dly", 32'(r.dly), 32'(4));
    r = model(16'h1234, 16'h5321);
`ifdef BCD_SIGN_MAG_EN
    chk("m_1234_5321", 32'({r.diff, r.borrow, r.neg}), 32'({16'h4087, 2'b11}));
    chk("m_dly_neg", 32'(r.dly), 32'(8));
`else
    chk("m_1234_5321", 32'({r.diff, r.borrow, r.neg}), 32'({16'h5913, 2'b11}));
    chk("m_dly_neg", 32'(r.dly), 32'(4));
`endif
    r = model(16'h0000, 16'h0001);
`ifdef BCD_SIGN_MAG_EN
    chk("m_0_1", 32'(r.diff), 32'(16'h0001));
`else
    chk("m_0_1", 32'(r.diff), 32'(16'h9999));
`endif
    r = model(16'h1000, 16'h0001);
    chk("m_1000_1", 32'(r.diff), 32'(16'h0999));

    run(16'h5321, 16'h1234);
    chk("t1_diff", 32'(diff), 32'(16'h4087));

    run(16'h1234, 16'h5321);
`ifdef BCD_SIGN_MAG_EN
    chk("t2_diff", 32'(diff), 32'(16'h4087));
`else
    chk("t2_diff", 32'(diff), 32'(16'h5913));
`endif
    chk("t2_neg", 32'({borrow, neg}), 32'(2'b11));

    run(16'h0000, 16'h0001);
    run(16'h9999, 16'h9999);
    chk("t4_diff", 32'(diff), 32'(16'h0000));
    run(16'h1000, 16'h0001);
    chk("t4b_diff", 32'(diff), 32'(16'h0999));

    launch(16'h0042, 16'h0017);
    @(negedge clk);
    a = 16'h9999;
    b = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    a = 16'h0003;
    b = 16'h0008;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_diff", 32'(diff), 32'(16'h0025));

    launch(16'h1234, 16'h5321);
    @(posedge clk);
    #2;
    ex_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'(0));
    chk("ar_done", 32'(done), 32'(0));
    chk("ar_diff", 32'(diff), 32'(0));
    chk("ar_borrow", 32'(borrow), 32'(0));
    chk("ar_neg", 32'(neg), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run(16'h5321, 16'h1234);
    chk("t6_diff", 32'(diff), 32'(16'h4087));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
